// File: rtl/inst_encoder_pkg.sv
// Shared types and helpers for the x86-64 instruction byte encoder.
// Fields are walked in emission order; a position is (field, byte index).
package inst_encoder_pkg;

  localparam int MAX_INST_LEN = 15;

  typedef struct packed {
    logic        rex_valid;
    logic [7:0]  rex;
    logic [1:0]  op_len;
    logic [23:0] opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [2:0]  disp_len;
    logic [31:0] disp;
    logic [3:0]  imm_len;
    logic [63:0] imm;
  } enc_req_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REX   = 3'd1,
    OPC   = 3'd2,
    MODRM = 3'd3,
    SIB   = 3'd4,
    DISP  = 3'd5,
    IMM   = 3'd6
  } enc_state_t;

  typedef struct packed {
    enc_state_t st;
    logic [3:0] cnt;
  } pos_t;

  function automatic enc_state_t next_field(
    enc_state_t s,
    enc_req_t   r
  );
    if (s < REX && r.rex_valid) return REX;
    if (s < OPC) return OPC;
    if (s < MODRM && r.has_modrm) return MODRM;
    if (s < SIB && r.has_sib) return SIB;
    if (s < DISP && r.disp_len != 3'd0) return DISP;
    if (s < IMM && r.imm_len != 4'd0) return IMM;
    return IDLE;
  endfunction

  function automatic pos_t next_pos(
    pos_t     p,
    enc_req_t r
  );
    pos_t       n;
    logic [3:0] c1;
    logic       more;
    c1 = p.cnt + 4'd1;
    case (p.st)
      OPC:     more = c1 < {2'b00, r.op_len};
      DISP:    more = c1 < {1'b0, r.disp_len};
      IMM:     more = c1 < r.imm_len;
      default: more = 1'b0;
    endcase
    if (more) begin
      n.st  = p.st;
      n.cnt = c1;
    end else begin
      n.st  = next_field(p.st, r);
      n.cnt = 4'd0;
    end
    return n;
  endfunction

  // Opcode goes out most-significant byte first; disp/imm little-endian.
  function automatic logic [7:0] field_byte(
    pos_t     p,
    enc_req_t r
  );
    logic [31:0] op32;
    logic [1:0]  k;
    op32 = {8'h00, r.opcode};
    k    = r.op_len - 2'd1 - p.cnt[1:0];
    case (p.st)
      REX:     return r.rex;
      OPC:     return op32[{k, 3'b000} +: 8];
      MODRM:   return r.modrm;
      SIB:     return r.sib;
      DISP:    return r.disp[{p.cnt[1:0], 3'b000} +: 8];
      IMM:     return r.imm[{p.cnt[2:0], 3'b000} +: 8];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_len_calc.sv
// Combinational length and well-formedness check for one request.
module enc_len_calc
  import inst_encoder_pkg::*;
#(
  parameter int MAX_LEN = MAX_INST_LEN
) (
  input  enc_req_t   req,
  output logic [4:0] len,
  output logic       ok
);

  logic op_ok;
  logic disp_ok;
  logic imm_ok;
  logic sib_ok;
  logic len_ok;

  always_comb begin
    len = 5'(req.rex_valid)
        + 5'(req.op_len)
        + 5'(req.has_modrm)
        + 5'(req.has_sib)
        + 5'(req.disp_len)
        + 5'(req.imm_len);
    op_ok   = req.op_len != 2'd0;
    disp_ok = req.disp_len inside {3'd0, 3'd1, 3'd2, 3'd4};
    imm_ok  = req.imm_len inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8};
    sib_ok  = !req.has_sib || req.has_modrm;
    len_ok  = int'(len) <= MAX_LEN;
    ok      = op_ok && disp_ok && imm_ok && sib_ok && len_ok;
  end

endmodule

// File: rtl/inst_encoder.sv
// Serializes a decoded-field request into an x86-64 byte stream,
// one byte per cycle, valid/ready on both sides.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int MAX_LEN = MAX_INST_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  enc_req_t   in_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic [3:0] out_len,
  output logic       err
);

  enc_state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  enc_req_t   req_q, req_d;
  logic       valid_d;
  logic [7:0] byte_d;
  logic       last_d;
  logic [3:0] len_d;
  logic       err_d;

  logic [4:0] calc_len;
  logic       calc_ok;
  logic       accept;
  logic       advance;
  enc_req_t   src;
  pos_t       cur;
  pos_t       load;
  pos_t       after;

  enc_len_calc #(
    .MAX_LEN(MAX_LEN)
  ) u_len (
    .req(in_req),
    .len(calc_len),
    .ok (calc_ok)
  );

  assign in_ready = (state == IDLE);

  // Each loaded position also looks one step ahead to flag the last byte.
  always_comb begin
    accept    = in_valid && in_ready;
    advance   = out_valid && out_ready;
    src       = accept ? in_req : req_q;
    cur.st    = state;
    cur.cnt   = cnt;
    load      = next_pos(cur, src);
    after     = next_pos(load, src);
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = req_q;
    valid_d = out_valid;
    byte_d  = out_byte;
    last_d  = out_last;
    len_d   = out_len;
    err_d   = 1'b0;
    if (accept) begin
      if (calc_ok) begin
        req_d   = in_req;
        state_d = load.st;
        cnt_d   = load.cnt;
        valid_d = 1'b1;
        byte_d  = field_byte(load, src);
        last_d  = (after.st == IDLE);
        len_d   = calc_len[3:0];
      end else begin
        err_d = 1'b1;
      end
    end else if (advance) begin
      if (out_last) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        valid_d = 1'b0;
        byte_d  = 8'h00;
        last_d  = 1'b0;
      end else begin
        state_d = load.st;
        cnt_d   = load.cnt;
        byte_d  = field_byte(load, src);
        last_d  = (after.st == IDLE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
      out_len   <= 4'd0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_q     <= req_d;
      out_valid <= valid_d;
      out_byte  <= byte_d;
      out_last  <= last_d;
      out_len   <= len_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: streams, backpressure, errors, reset.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  enc_req_t   in_req;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic [3:0] out_len;
  logic       err;

  int pass = 0;
  int total = 0;

  inst_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_req   (in_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_last (out_last),
    .out_len  (out_len),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic enc_req_t mk(
    logic rv, logic [7:0] rx,
    logic [1:0] ol, logic [23:0] op,
    logic hm, logic [7:0] m,
    logic hs, logic [7:0] s,
    logic [2:0] dl, logic [31:0] d,
    logic [3:0] il, logic [63:0] im
  );
    enc_req_t r;
    r.rex_valid = rv;
    r.rex       = rx;
    r.op_len    = ol;
    r.opcode    = op;
    r.has_modrm = hm;
    r.modrm     = m;
    r.has_sib   = hs;
    r.sib       = s;
    r.disp_len  = dl;
    r.disp      = d;
    r.imm_len   = il;
    r.imm       = im;
    return r;
  endfunction

  function automatic enc_req_t req_push();
    return mk(0, 0, 1, 24'h50, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic enc_req_t req_add();
    return mk(1, 8'h48, 1, 24'h05, 0, 0, 0, 0,
              0, 0, 4, 64'h12345678);
  endfunction

  // Called at #1 after a posedge; returns at #1 after the accept edge.
  task automatic drive(input enc_req_t r);
    in_req   = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_req   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_req = '0;
    out_ready = 1'b1;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_byte !== 8'h00 || out_last !== 1'b0 ||
        out_len !== 4'd0 || err !== 1'b0) begin
      $display("FAIL reset: rdy=%b v=%b b=%h l=%b len=%0d err=%b want 1 0 00 0 0 0",
               in_ready, out_valid, out_byte, out_last, out_len, err);
    end else pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_push();
    drive(req_push());
    total++;
    if (out_valid !== 1'b1 || out_byte !== 8'h50 ||
        out_last !== 1'b1 || out_len !== 4'd1 || in_ready !== 1'b0) begin
      $display("FAIL push: v=%b b=%h l=%b len=%0d rdy=%b want 1 50 1 1 0",
               out_valid, out_byte, out_last, out_len, in_ready);
    end else pass++;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_len !== 4'd1) begin
      $display("FAIL push_idle: rdy=%b v=%b len=%0d want 1 0 1",
               in_ready, out_valid, out_len);
    end else pass++;
  endtask

  task automatic test_add();
    logic [7:0] e [6] = '{8'h48, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12};
    drive(req_add());
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_byte !== e[i] ||
          out_last !== (i == 5) || out_len !== 4'd6) begin
        $display("FAIL add[%0d]: v=%b b=%h l=%b len=%0d want b=%h l=%b len=6",
                 i, out_valid, out_byte, out_last, out_len, e[i], i == 5);
      end else pass++;
      @(posedge clk); #1;
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL add_idle: rdy=%b v=%b want 1 0", in_ready, out_valid);
    end else pass++;
  endtask

  task automatic test_jz();
    logic [7:0] e [6] = '{8'h0F, 8'h84, 8'h00, 8'h01, 8'h00, 8'h00};
    drive(mk(0, 0, 2, 24'h000F84, 0, 0, 0, 0, 0, 0, 4, 64'h100));
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_byte !== e[i] ||
          out_last !== (i == 5) || out_len !== 4'd6) begin
        $display("FAIL jz[%0d]: v=%b b=%h l=%b len=%0d want b=%h l=%b len=6",
                 i, out_valid, out_byte, out_last, out_len, e[i], i == 5);
      end else pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mov();
    logic [7:0] e [8] = '{8'hC7, 8'h44, 8'h88, 8'h10,
                          8'hEF, 8'hBE, 8'hAD, 8'hDE};
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL mov_ready: rdy=%b want 1", in_ready);
    end else pass++;
    drive(mk(0, 0, 1, 24'hC7, 1, 8'h44, 1, 8'h88,
             1, 32'h10, 4, 64'hDEADBEEF));
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_byte !== e[i] ||
          out_last !== (i == 7) || out_len !== 4'd8) begin
        $display("FAIL mov[%0d]: v=%b b=%h l=%b len=%0d want b=%h l=%b len=8",
                 i, out_valid, out_byte, out_last, out_len, e[i], i == 7);
      end else pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [6] = '{8'h48, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12};
    int i = 0;
    int st = 0;
    drive(req_add());
    while (i < 6) begin
      total++;
      if (out_valid !== 1'b1 || out_byte !== e[i] ||
          out_last !== (i == 5) || out_len !== 4'd6) begin
        $display("FAIL bp[%0d] stall=%0d: v=%b b=%h l=%b len=%0d want b=%h l=%b",
                 i, st, out_valid, out_byte, out_last, out_len, e[i], i == 5);
      end else pass++;
      if (i == 1 && st < 3) begin
        out_ready = 1'b0;
        st++;
      end else begin
        out_ready = 1'b1;
        i++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_idle: rdy=%b v=%b want 1 0", in_ready, out_valid);
    end else pass++;
  endtask

  task automatic test_malformed();
    enc_req_t bad [3];
    bad[0] = mk(1, 8'h48, 3, 24'h0F3800, 1, 8'h04, 1, 8'h00,
                4, 32'h1, 8, 64'h1);
    bad[1] = mk(0, 0, 0, 24'h90, 0, 0, 0, 0, 0, 0, 0, 0);
    bad[2] = mk(0, 0, 1, 24'h8B, 0, 0, 1, 8'h24, 0, 0, 0, 0);
    drive(bad[0]);
    total++;
    if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bad_len: err=%b v=%b rdy=%b want 1 0 1",
               err, out_valid, in_ready);
    end else pass++;
    @(posedge clk); #1;
    total++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL err_pulse: err=%b v=%b want 0 0", err, out_valid);
    end else pass++;
    for (int k = 1; k < 3; k++) begin
      drive(bad[k]);
      total++;
      if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL bad[%0d]: err=%b v=%b rdy=%b want 1 0 1",
                 k, err, out_valid, in_ready);
      end else pass++;
    end
    drive(req_push());
    total++;
    if (err !== 1'b0 || out_valid !== 1'b1 || out_byte !== 8'h50) begin
      $display("FAIL after_err: err=%b v=%b b=%h want 0 1 50",
               err, out_valid, out_byte);
    end else pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e [6] = '{8'h48, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12};
    drive(req_add());
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (out_byte !== 8'h78) begin
      $display("FAIL mid_pre: b=%h want 78", out_byte);
    end else pass++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_byte !== 8'h00 || out_last !== 1'b0 ||
        out_len !== 4'd0 || err !== 1'b0) begin
      $display("FAIL mid_reset: rdy=%b v=%b b=%h l=%b len=%0d err=%b want 1 0 00 0 0 0",
               in_ready, out_valid, out_byte, out_last, out_len, err);
    end else pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL mid_quiet: v=%b rdy=%b want 0 1", out_valid, in_ready);
    end else pass++;
    drive(req_add());
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_byte !== e[i] ||
          out_last !== (i == 5) || out_len !== 4'd6) begin
        $display("FAIL re_add[%0d]: v=%b b=%h l=%b len=%0d want b=%h l=%b",
                 i, out_valid, out_byte, out_last, out_len, e[i], i == 5);
      end else pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_add();
    test_jz();
    test_mov();
    test_backpressure();
    test_malformed();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Byte-stream instruction encoder: the inverse of the opcode-map decode path. Accepts one decoded-field request (REX, 1–3 opcode bytes, optional ModRM/SIB, displacement, immediate) over a valid/ready handshake and serializes it as a little-endian x86-64 byte stream, one byte per cycle, with backpressure. Used to generate fetch-side stimulus, re-emit retired instructions for trace/replay, and close the decode round trip in self-checking benches.

## Interface
Parameters:
- MAX_LEN, 15: architectural instruction-length limit in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder idle and able to accept.
- in_req  in  enc_req_t  request fields (see Structure).
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- out_byte  out  8  current instruction byte.
- out_last  out  1  out_byte is the final byte of the instruction.
- out_len  out  4  total length of the instruction being emitted; stable for the whole emission.
- err  out  1  one-cycle pulse: last accepted request was malformed; nothing emitted.

## Operation
- Accept when in_valid && in_ready. in_ready = (state == IDLE).
- Validation at accept (combinational, via enc_len_calc): op_len in 1..3; disp_len in {0,1,2,4}; imm_len in {0,1,2,4,8}; has_sib requires has_modrm; total = rex_valid + op_len + has_modrm + has_sib + disp_len + imm_len ≤ MAX_LEN. Any failure → err pulses next cycle, state stays IDLE, no bytes.
- Request latched into holding registers on accept; later in_req changes have no effect.
- Emission order: REX, opcode, ModRM, SIB, displacement, immediate.
- Opcode field is 24 bits, right-aligned, first-emitted byte most significant: op_len=1 emits opcode[7:0]; op_len=2 emits [15:8] then [7:0]; op_len=3 emits [23:16], [15:8], [7:0] (e.g. 0F 38 xx).
- disp and imm emitted little-endian, low byte first, truncated to their lengths.
- FSM: IDLE → REX → OPC → MODRM → SIB → DISP → IMM → IDLE; absent fields skipped in the transition (no empty cycles). 4-bit byte counter within OPC/DISP/IMM; advances only on out_valid && out_ready.
- out_last = 1 exactly on the final byte; leaving that byte returns to IDLE.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, out_byte=0, out_last=0, out_len=0, err=0, counters cleared. Reset mid-emission aborts the instruction; no further bytes, no partial completion.
- All outputs registered except in_ready (decoded from state register).
- Accept in cycle N → first byte valid in N+1. With out_ready held high, an L-byte instruction occupies cycles N+1..N+L; in_ready high again at N+L+1. Throughput: L+1 cycles per instruction.
- out_ready low: out_byte, out_last, out_len held stable, out_valid stays 1 (no retraction).
- err: accept in N → err=1 in N+1 only; in_ready stays 1, so a new request may be accepted in N+1.
- out_len loads at N+1, holds through the last byte, then holds its value while idle.

## Structure
- Utilities package additions: enc_req_t packed struct {rex_valid:1, rex:8, op_len:2, opcode:24, has_modrm:1, modrm:8, has_sib:1, sib:8, disp_len:3, disp:32, imm_len:4, imm:64}; enc_state_t enum; constant MAX_INST_LEN = 15.
- Sub-module enc_len_calc: combinational; enc_req_t in → total length (5 bits) and valid flag. Shared with the bench's length checker.

## Test plan
- push rax: op_len=1, opcode=0x000050, everything else absent → single byte 50, out_last=1, out_len=1, in_ready back 2 cycles after accept.
- add rax, imm32: REX 48, opcode 0x000005, imm_len=4, imm=0x12345678 → 48 05 78 56 34 12, out_last only on 12, out_len=6.
- jz rel32: op_len=2, opcode=0x000F84, imm_len=4, imm=0x100 → 0F 84 00 01 00 00; mov [rax+rcx*4+0x10], imm32 → C7 44 88 10 + 4 imm bytes with ModRM/SIB/disp8 in order.
- Backpressure: drop out_ready for 3 cycles after byte 2 of the add case → byte 05 held stable with out_valid=1; stream resumes unchanged; no duplicate or lost byte.
- Malformed: REX + op_len=3 + ModRM + SIB + disp4 + imm8 (18 bytes), plus op_len=0 and has_sib without has_modrm → one-cycle err each, out_valid never asserted, next valid request accepted the following cycle.
- Reset asserted during byte 3 of a 6-byte instruction → outputs at reset values immediately; after release, next request emits from its first byte.
